bilbo_bist_ctrl: RTL and testbench

BIST sequencer that drives a generator/compactor BILBO pair.
- Serially loads a seed into the generator BILBO and clears the compactor BILBO.
- Runs PRPG/MISR for a fixed number of cycles.
- Unloads the compactor signature through its So pin and compares it against a golden value.
- Sits between the test-access logic (Start/Done/Pass) and the BILBO control pins (CE, B1, B2, Si, So).

---
 rtl/bilbo_pkg.sv | 23 ++
 rtl/bilbo_sig_capture.sv | 36 +++
 rtl/bilbo_bist_ctrl.sv | 170 +++++++++++++++++
 tb/tb_bilbo_bist_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bilbo_pkg.sv
// rtl/bilbo_pkg.sv - BILBO mode codes and BIST sequencer state encoding
package bilbo_pkg;

  // {B1,B2} mode codes shared by the generator and compactor BILBOs
  localparam logic [1:0] MODE_SHIFT  = 2'b00;
  localparam logic [1:0] MODE_PRPG   = 2'b01;
  localparam logic [1:0] MODE_NORMAL = 2'b10;
  localparam logic [1:0] MODE_MISR   = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEED    = 3'd1,
    RUN     = 3'd2,
    UNLOAD  = 3'd3,
    COMPARE = 3'd4,
    DONE    = 3'd5
  } bist_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bilbo_sig_capture.sv
// rtl/bilbo_sig_capture.sv - serial signature capture register with golden compare
module bilbo_sig_capture
#(
  parameter int NBITS = 4
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             cmp_en,
  input  logic             so_in,
  input  logic [1:NBITS]   golden,
  output logic [1:NBITS]   sig,
  output logic             pass
);

  // The first bit shifted in is compactor Q[NBITS]; it walks down to sig[NBITS]
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig  <= '0;
      pass <= 1'b0;
    end else if (clear) begin
      sig  <= '0;
      pass <= 1'b0;
    end else begin
      if (shift_en) begin
        sig <= {so_in, sig[1:NBITS-1]};
      end
      if (cmp_en) begin
        pass <= (sig == golden);
      end
    end
  end

endmodule

// File: rtl/bilbo_bist_ctrl.sv
// rtl/bilbo_bist_ctrl.sv - BILBO generator/compactor BIST sequencer (option: BILBO_SIG_RESTORE_EN)
module bilbo_bist_ctrl
  import bilbo_pkg::*;
#(
  parameter int NBITS     = 4,
  parameter int NPATTERNS = 15
)
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [1:NBITS]   Seed,
  input  logic [1:NBITS]   Golden,
  input  logic             So_cmp,
  output logic             CE,
  output logic             B1_gen,
  output logic             B2_gen,
  output logic             B1_cmp,
  output logic             B2_cmp,
  output logic             Si_gen,
  output logic             Si_cmp,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [1:NBITS]   Sig
);

  if (NBITS < 2 || NPATTERNS < 1) begin : g_param_check
    $error("bilbo_bist_ctrl: NBITS must be >= 2 and NPATTERNS >= 1");
  end

  localparam int CW = $clog2(max_int(NBITS, NPATTERNS));
  localparam logic [CW-1:0] SHIFT_LAST = CW'(NBITS - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(NPATTERNS - 1);

  bist_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:NBITS]   seed_reg, golden_reg;
  logic [1:0]       gen_mode, cmp_mode;
  logic             accept, shift_en, cmp_en;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      seed_reg   <= '0;
      golden_reg <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        seed_reg   <= Seed;
        golden_reg <= Golden;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    CE       = 1'b0;
    gen_mode = MODE_NORMAL;
    cmp_mode = MODE_NORMAL;
    Si_gen   = 1'b0;
    Si_cmp   = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    accept   = 1'b0;
    shift_en = 1'b0;
    cmp_en   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = SEED;
        end
      end

      SEED: begin
        CE       = 1'b1;
        Busy     = 1'b1;
        gen_mode = MODE_SHIFT;
        cmp_mode = MODE_SHIFT;
        // Seed[NBITS] goes first so the generator holds Seed in Q[1:NBITS] on exit
        for (int i = 1; i <= NBITS; i++) begin
          if (i == NBITS - int'(cnt_q)) begin
            Si_gen = seed_reg[i];
          end
        end
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RUN: begin
        CE       = 1'b1;
        Busy     = 1'b1;
        gen_mode = MODE_PRPG;
        cmp_mode = MODE_MISR;
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      UNLOAD: begin
        CE       = 1'b1;
        Busy     = 1'b1;
        gen_mode = MODE_NORMAL;
        cmp_mode = MODE_SHIFT;
        shift_en = 1'b1;
`ifdef BILBO_SIG_RESTORE_EN
        // Rotate the compactor so it still holds the signature afterwards
        Si_cmp   = So_cmp;
`else
        Si_cmp   = 1'b0;
`endif
        if (cnt_q == SHIFT_LAST) begin
          cnt_d   = '0;
          state_d = COMPARE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      COMPARE: begin
        Busy    = 1'b1;
        cmp_en  = 1'b1;
        cnt_d   = '0;
        state_d = DONE;
      end

      DONE: begin
        Done    = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign {B1_gen, B2_gen} = gen_mode;
  assign {B1_cmp, B2_cmp} = cmp_mode;

  bilbo_sig_capture #(
    .NBITS (NBITS)
  ) u_sig_capture (
    .clk      (Clk),
    .rst      (Rst),
    .clear    (accept),
    .shift_en (shift_en),
    .cmp_en   (cmp_en),
    .so_in    (So_cmp),
    .golden   (golden_reg),
    .sig      (Sig),
    .pass     (Pass)
  );

endmodule

// File: tb/tb_bilbo_bist_ctrl.sv
// tb/tb_bilbo_bist_ctrl.sv - directed bench for bilbo_bist_ctrl with generator/compactor BILBO models
module tb_bilbo_bist_ctrl;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Start = 1'b0;
  logic [1:4]   Seed = '0;
  logic [1:4]   Golden = '0;
  logic         So_cmp;
  logic         CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp;
  logic         Busy, Done, Pass;
  logic [1:4]   Sig;

  int checks = 0;
  int errors = 0;

  logic         use_model = 1'b0;
  logic         tb_so = 1'b0;
  logic [1:4]   zflip = '0;
  logic [1:4]   gen_q = '0;
  logic [1:4]   cmp_q = '0;

  always #5 Clk = ~Clk;

  assign So_cmp = use_model ? cmp_q[4] : tb_so;

  bilbo_bist_ctrl #(
    .NBITS     (4),
    .NPATTERNS (15)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .Seed   (Seed),
    .Golden (Golden),
    .So_cmp (So_cmp),
    .CE     (CE),
    .B1_gen (B1_gen),
    .B2_gen (B2_gen),
    .B1_cmp (B1_cmp),
    .B2_cmp (B2_cmp),
    .Si_gen (Si_gen),
    .Si_cmp (Si_cmp),
    .Busy   (Busy),
    .Done   (Done),
    .Pass   (Pass),
    .Sig    (Sig)
  );

  // BILBO with feedback x^4+x^3+1
  function automatic logic [1:4] bilbo_next(input logic [1:4] q, input logic [1:0] m,
                                           input logic si, input logic [1:4] z);
    case (m)
      2'b00:   return {si, q[1:3]};
      2'b01:   return {q[3] ^ q[4], q[1:3]};
      2'b10:   return z;
      default: return {q[3] ^ q[4], q[1:3]} ^ z;
    endcase
  endfunction

  always @(posedge Clk) begin
    if (CE) begin
      gen_q <= bilbo_next(gen_q, {B1_gen, B2_gen}, Si_gen, 4'b0000);
      cmp_q <= bilbo_next(cmp_q, {B1_cmp, B2_cmp}, Si_cmp, gen_q ^ zflip);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Starts in IDLE at #1 after an edge; returns #1 after the accepting edge
  task automatic accept_start(input logic [1:4] s, input logic [1:4] g);
    Seed   = s;
    Golden = g;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    #2;
    checks++;
    if ({CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done, Pass} !== 10'b0_10_10_00_000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done, Pass}, 10'b0_10_10_00_000);
    end
    checks++;
    if (Sig !== 4'b0000) begin
      errors++;
      $display("FAIL reset_sig: got %b expected 0000", Sig);
    end
    tick();
    tick();
    Rst = 1'b0;
    tick();
    checks++;
    if ({CE, Busy, Done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 000", {CE, Busy, Done});
    end
  endtask

  task automatic test_timing();
    logic [8:0] exp_v;
    logic [3:0] exp_m;
    int ce_cnt;
    int first_done;
    ce_cnt = 0;
    first_done = -1;
    use_model = 1'b0;
    tb_so = 1'b0;
    accept_start(4'b1000, 4'b0000);
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) tick();
      if (k < 4)       exp_m = 4'b0000;
      else if (k < 19) exp_m = 4'b0111;
      else if (k < 23) exp_m = 4'b1000;
      else             exp_m = 4'b1010;
      exp_v = {(k <= 22), exp_m, (k == 3), 1'b0, (k <= 23), (k == 24)};
      checks++;
      if ({CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done} !== exp_v) begin
        errors++;
        $display("FAIL timing_k%0d: got %b expected %b", k,
                 {CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done}, exp_v);
      end
      if (CE) ce_cnt++;
      if (Done && first_done < 0) first_done = k;
      if (k == 24) begin
        checks++;
        if ({Pass, Sig} !== 5'b1_0000) begin
          errors++;
          $display("FAIL timing_result: got %b expected 10000", {Pass, Sig});
        end
      end
    end
    checks++;
    if (ce_cnt != 23) begin
      errors++;
      $display("FAIL ce_cycles: got %0d expected 23", ce_cnt);
    end
    checks++;
    if (first_done != 24) begin
      errors++;
      $display("FAIL done_latency: got %0d expected 24", first_done);
    end
  endtask

  task automatic test_start_ignored();
    use_model = 1'b0;
    tb_so = 1'b0;
    accept_start(4'b1000, 4'b0000);
    Seed = 4'b0111;
    Golden = 4'b1111;
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) tick();
      if (k == 2 || k == 10 || k == 20) Start = 1'b1;
      if (k == 3 || k == 13 || k == 21) Start = 1'b0;
      checks++;
      if ({Si_gen, Busy, Done} !== {(k == 3), (k <= 23), (k == 24)}) begin
        errors++;
        $display("FAIL start_ignored_k%0d: got %b expected %b", k,
                 {Si_gen, Busy, Done}, {(k == 3), (k <= 23), (k == 24)});
      end
    end
    checks++;
    if (Pass !== 1'b1) begin
      errors++;
      $display("FAIL golden_capture: got %b expected 1", Pass);
    end
  endtask

  task automatic test_standalone(input logic [1:4] g, input logic exp_pass);
    logic [0:3] so_seq;
    so_seq = 4'b1011;
    use_model = 1'b0;
    tb_so = 1'b0;
    accept_start(4'b1010, g);
    for (int k = 1; k <= 24; k++) begin
      tick();
      tb_so = (k >= 19 && k <= 22) ? so_seq[2'(k - 19)] : 1'b0;
    end
    checks++;
    if ({Done, Sig, Pass} !== {1'b1, 4'b1101, exp_pass}) begin
      errors++;
      $display("FAIL standalone_g%b: got done/sig/pass %b expected %b", g,
               {Done, Sig, Pass}, {1'b1, 4'b1101, exp_pass});
    end
    tick();
    checks++;
    if ({Done, Sig, Pass} !== {1'b0, 4'b1101, exp_pass}) begin
      errors++;
      $display("FAIL standalone_hold_g%b: got %b expected %b", g,
               {Done, Sig, Pass}, {1'b0, 4'b1101, exp_pass});
    end
  endtask

  task automatic test_closed_loop();
    use_model = 1'b1;
    zflip = '0;
    accept_start(4'b0001, 4'b0011);
    for (int k = 1; k <= 24; k++) tick();
    checks++;
    if ({Done, Pass, Sig} !== {2'b11, 4'b0011}) begin
      errors++;
      $display("FAIL closed_loop: got done/pass/sig %b expected 110011", {Done, Pass, Sig});
    end
`ifdef BILBO_SIG_RESTORE_EN
    checks++;
    if (cmp_q !== 4'b0011) begin
      errors++;
      $display("FAIL compactor_restored: got %b expected 0011", cmp_q);
    end
`else
    checks++;
    if (cmp_q !== 4'b0000) begin
      errors++;
      $display("FAIL compactor_cleared: got %b expected 0000", cmp_q);
    end
`endif
    tick();
  endtask

  task automatic test_fault();
    use_model = 1'b1;
    zflip = '0;
    accept_start(4'b0001, 4'b0011);
    for (int k = 1; k <= 24; k++) begin
      tick();
      zflip = (k == 10) ? 4'b0100 : 4'b0000;
    end
    checks++;
    if ({Done, Pass, Sig} !== {2'b10, 4'b1110}) begin
      errors++;
      $display("FAIL fault_detect: got done/pass/sig %b expected 101110", {Done, Pass, Sig});
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int first_done;
    first_done = -1;
    use_model = 1'b1;
    accept_start(4'b0001, 4'b0011);
    for (int k = 1; k <= 11; k++) tick();
    #2;
    Rst = 1'b1;
    #1;
    checks++;
    if ({CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done, Pass, Sig} !== 14'b0_10_10_00_000_0000) begin
      errors++;
      $display("FAIL reset_mid_run: got %b expected %b",
               {CE, B1_gen, B2_gen, B1_cmp, B2_cmp, Si_gen, Si_cmp, Busy, Done, Pass, Sig}, 14'b0_10_10_00_000_0000);
    end
    tick();
    Rst = 1'b0;
    tick();
    accept_start(4'b0001, 4'b0011);
    for (int k = 1; k <= 30 && first_done < 0; k++) begin
      tick();
      if (Done) first_done = k;
    end
    checks++;
    if (first_done != 24) begin
      errors++;
      $display("FAIL restart_latency: got %0d expected 24", first_done);
    end
    checks++;
    if ({Pass, Sig} !== 5'b1_0011) begin
      errors++;
      $display("FAIL restart_result: got %b expected 10011", {Pass, Sig});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int done_cnt;
    done_cnt = 0;
    use_model = 1'b1;
    Seed = 4'b0001;
    Golden = 4'b0011;
    Start = 1'b1;
    tick();
    for (int k = 1; k <= 52; k++) begin
      tick();
      if (k == 49) Start = 1'b0;
      if (Done) done_cnt++;
      if (k == 24 || k == 50) begin
        checks++;
        if ({Done, Pass, Sig} !== {2'b11, 4'b0011}) begin
          errors++;
          $display("FAIL b2b_done_k%0d: got %b expected 110011", k, {Done, Pass, Sig});
        end
      end
      if (k == 25) begin
        checks++;
        if ({CE, Busy, Done} !== 3'b000) begin
          errors++;
          $display("FAIL b2b_idle_gap: got %b expected 000", {CE, Busy, Done});
        end
      end
      if (k == 26) begin
        checks++;
        if ({CE, Busy, Pass, Sig} !== 7'b11_0_0000) begin
          errors++;
          $display("FAIL b2b_restart: got %b expected 1100000", {CE, Busy, Pass, Sig});
        end
      end
    end
    checks++;
    if (done_cnt != 2 || CE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_count: got dones %0d ce %b expected 2 0", done_cnt, CE);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_start_ignored();
    test_standalone(4'b1101, 1'b1);
    test_standalone(4'b1100, 1'b0);
    test_closed_loop();
    test_fault();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

endmodule
